// File: rtl/lsosc_pkg.sv
// Shared types and constants for the low-speed oscillator model.
// Optional feature macro: LSOSC_READY_EN (adds the osc_ready output).
package lsosc_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    STARTUP = 2'd1,
    RUN     = 2'd2
  } lsosc_state_e;

  localparam int LSOSC_HALF_PERIOD_DEF = 2400;
  localparam int LSOSC_PU_DELAY_DEF    = 16;

  // Counter width able to hold the largest terminal value (max - 1).
  function automatic int lsosc_cnt_width(input int half_period, input int pu_delay);
    int m;
    m = (half_period > pu_delay) ? half_period : pu_delay;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lsosc_sync2.sv
// Two-flop synchronizer with synchronous active-low clear.
module lsosc_sync2
  import lsosc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Capture the asynchronous input and resolve metastability over two stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/lsosc_model.sv
// Behavioural, synthesizable stand-in for the iCE40 low-speed oscillator.
// Optional feature macro: LSOSC_READY_EN (adds osc_ready, high while in RUN).
module lsosc_model
  import lsosc_pkg::*;
#(
  parameter int HALF_PERIOD = LSOSC_HALF_PERIOD_DEF,
  parameter int PU_DELAY    = LSOSC_PU_DELAY_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_lf_pu,
  input  logic clk_lf_en,
`ifdef LSOSC_READY_EN
  output logic osc_ready,
`endif
  output logic clk_lf
);

  localparam int            CW      = lsosc_cnt_width(HALF_PERIOD, PU_DELAY);
  localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] PU_LAST = CW'(PU_DELAY - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic         w_pu_s;
  logic         w_en_s;
  lsosc_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic         r_phase;
  logic         r_en_lat;
  logic         r_clk_lf;

  lsosc_sync2 u_sync_pu (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (clk_lf_pu),
    .o_q   (w_pu_s)
  );

  lsosc_sync2 u_sync_en (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (clk_lf_en),
    .o_q   (w_en_s)
  );

  // Oscillator FSM, divider, glitch-free enable latch and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= OFF;
      r_cnt    <= '0;
      r_phase  <= 1'b0;
      r_en_lat <= 1'b0;
      r_clk_lf <= 1'b0;
    end else begin
      // Enable only changes while the output is low, so no runt pulses.
      if (!r_phase) begin
        r_en_lat <= w_en_s;
      end
      r_clk_lf <= (r_state == RUN) ? (r_phase & r_en_lat) : 1'b0;

      case (r_state)
        OFF: begin
          r_cnt   <= '0;
          r_phase <= 1'b0;
          if (w_pu_s) begin
            r_state <= STARTUP;
          end
        end
        STARTUP: begin
          r_phase <= 1'b0;
          if (!w_pu_s) begin
            r_state <= OFF;
            r_cnt   <= '0;
          end else if (r_cnt == PU_LAST) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        RUN: begin
          if (!w_pu_s) begin
            r_state <= OFF;
            r_cnt   <= '0;
            r_phase <= 1'b0;
          end else if (r_cnt == HP_LAST) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= OFF;
          r_cnt   <= '0;
          r_phase <= 1'b0;
        end
      endcase
    end
  end

  assign clk_lf = r_clk_lf;

`ifdef LSOSC_READY_EN
  logic r_osc_ready;

  // Tracks the next FSM state so the flag is high exactly while in RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_osc_ready <= 1'b0;
    end else begin
      r_osc_ready <= w_pu_s &&
                     ((r_state == RUN) || ((r_state == STARTUP) && (r_cnt == PU_LAST)));
    end
  end

  assign osc_ready = r_osc_ready;
`endif

endmodule

// File: tb/tb_lsosc_model.sv
// Self-checking bench for lsosc_model (HALF_PERIOD=4, PU_DELAY=8), directed plus random.
// Compile with +define+LSOSC_READY_EN to also check osc_ready.
module tb_lsosc_model;

  localparam int HP = 4;
  localparam int PU = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pu = 1'b0;
  logic en = 1'b0;
  logic clk_lf;
`ifdef LSOSC_READY_EN
  logic osc_ready;
`endif

  always #5 clk = ~clk;

  lsosc_model #(.HALF_PERIOD(HP), .PU_DELAY(PU)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_lf_pu (pu),
    .clk_lf_en (en),
`ifdef LSOSC_READY_EN
    .osc_ready (osc_ready),
`endif
    .clk_lf    (clk_lf)
  );

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  // Reference model: state 0=off 1=startup 2=run; timing derived from edge numbers.
  int m_state = 0;
  int m_start_edge = 0;
  int m_run_edge = 0;
  bit m_len = 1'b0;
  bit pu_d1 = 1'b0, pu_d2 = 1'b0, en_d1 = 1'b0, en_d2 = 1'b0;
  bit exp_clk = 1'b0;
  bit exp_rdy = 1'b0;

  function automatic bit m_phase();
    if (m_state != 2) return 1'b0;
    return (((edge_n - m_run_edge) / HP) % 2) == 1;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at edge %0d: observed %0b expected %0b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit ph_b, run_b, pu_s_b, en_s_b;
    @(posedge clk);
    ph_b   = m_phase();
    run_b  = (m_state == 2);
    pu_s_b = pu_d2;
    en_s_b = en_d2;
    edge_n++;
    if (!rst_n) begin
      m_state = 0;
      m_len   = 1'b0;
      pu_d1 = 1'b0; pu_d2 = 1'b0; en_d1 = 1'b0; en_d2 = 1'b0;
      exp_clk = 1'b0;
    end else begin
      exp_clk = run_b & ph_b & m_len;
      if (!ph_b) m_len = en_s_b;
      pu_d2 = pu_d1; pu_d1 = pu;
      en_d2 = en_d1; en_d1 = en;
      if (!pu_s_b) begin
        m_state = 0;
      end else if (m_state == 0) begin
        m_state = 1;
        m_start_edge = edge_n;
      end else if ((m_state == 1) && (edge_n - m_start_edge == PU)) begin
        m_state = 2;
        m_run_edge = edge_n;
      end
    end
    exp_rdy = (m_state == 2);
    #1;
    chk("clk_lf", clk_lf, exp_clk);
`ifdef LSOSC_READY_EN
    chk("osc_ready", osc_ready, exp_rdy);
`endif
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_rise(input string tag, input int bound, output int at);
    logic prev;
    bit found;
    found = 1'b0;
    at = -1;
    prev = clk_lf;
    for (int i = 0; i < bound && !found; i++) begin
      tick();
      if (prev === 1'b0 && clk_lf === 1'b1) begin
        found = 1'b1;
        at = edge_n;
      end
      prev = clk_lf;
    end
    chk(tag, found, 1'b1);
  endtask

  initial begin
    int e0, r0, r1, r2;
    // 1: reset held with pu/en high, then release
    rst_n = 1'b0; pu = 1'b1; en = 1'b1;
    ticks(3);
    rst_n = 1'b1;
    e0 = edge_n + 1;
    // 2: first rise 15 cycles after pu seen, then 50% duty
    wait_rise("first_rise_found", 40, r0);
    chk_int("first_rise_latency", r0 - e0, 15);
    ticks(16);
    // 3: drop en just after a rise; high phase completes, re-enable stays on grid
    wait_rise("rise_before_en_drop", 20, r0);
    tick();
    en = 1'b0;
    ticks(14);
    en = 1'b1;
    wait_rise("rise_after_reenable", 40, r1);
    chk_int("reenable_grid", (r1 - r0) % (2 * HP), 0);
    // 4: drop pu while high; output low within 3 cycles, full startup again
    wait_rise("rise_before_pu_drop", 20, r0);
    tick();
    pu = 1'b0;
    ticks(3);
    chk("pu_drop_low", clk_lf, 1'b0);
    ticks(10);
    pu = 1'b1;
    e0 = edge_n + 1;
    wait_rise("rise_after_pu_again", 40, r1);
    chk_int("pu_restart_latency", r1 - e0, 15);
    // 5: powered but disabled, then enable aligns to phase grid
    en = 1'b0;
    ticks(30);
    en = 1'b1;
    wait_rise("rise_after_enable", 40, r2);
    chk_int("enable_grid", (r2 - r1) % (2 * HP), 0);
    // 6: one-cycle reset mid-RUN
    ticks(3);
    rst_n = 1'b0;
    tick();
    chk("reset_mid_run_low", clk_lf, 1'b0);
    rst_n = 1'b1;
    e0 = edge_n + 1;
    wait_rise("rise_after_reset", 40, r0);
    chk_int("reset_restart_latency", r0 - e0, 15);
    // Random phase: occasional toggles of pu/en and rare resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0) pu = ~pu;
      if ($urandom_range(0, 9) == 0) en = ~en;
      rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
